// File: rtl/fp_mul_normalize_round_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_normalize_round_pkg : FSM states and format-width helpers (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fp_mul_normalize_round_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int exp_w_of(input int x);
    return (x == 64) ? 11 : 8;
  endfunction

  function automatic int man_w_of(input int x);
    return x - exp_w_of(x) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne : combinational round-to-nearest-even on {sig,G,S,exp} (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fp_round_rne
  import fp_mul_normalize_round_pkg::*;
#(
  parameter int MAN_W = 23,
  parameter int EW    = 11
) (
  input  logic [MAN_W:0]        sig_i,
  input  logic                  g_i,
  input  logic                  s_i,
  input  logic signed [EW-1:0]  exp_i,
  output logic [MAN_W:0]        sig_o,
  output logic signed [EW-1:0]  exp_o,
  output logic                  carry_o,
  output logic                  inexact_o
);

  logic             round_up;
  logic [MAN_W+1:0] sum;

  assign round_up  = g_i & (s_i | sig_i[0]);
  assign sum       = {1'b0, sig_i} + {{(MAN_W+1){1'b0}}, round_up};
  // A carry-out leaves sig_o all zero, i.e. 1.000... at the next exponent.
  assign carry_o   = sum[MAN_W+1];
  assign sig_o     = sum[MAN_W:0];
  assign exp_o     = exp_i + {{(EW-1){1'b0}}, carry_o};
  assign inexact_o = g_i | s_i;

endmodule

`default_nettype wire

// File: rtl/fp_mul_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_mul_normalize_round : iterative normalise / denormalise / RNE round stage
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_mul_normalize_round
  import fp_mul_normalize_round_pkg::*;
#(
  parameter  int X     = 32,
  localparam int EXP_W = exp_w_of(X),
  localparam int MAN_W = man_w_of(X)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exp,
  input  logic [2*MAN_W+1:0]   in_prod,
  input  logic                 in_special,
  input  logic [X-1:0]         in_special_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X-1:0]         out,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);

  localparam int M   = MAN_W;
  localparam int PW  = 2*M + 2;
  localparam int EIW = EXP_W + 3;
  localparam logic signed [EIW-1:0] C_EXP_ONE   = EIW'(1);
  localparam logic signed [EIW-1:0] C_EXP_FLOOR = EIW'(-(M + 2));
  localparam logic signed [EIW-1:0] C_EXP_MAX   = EIW'((1 << EXP_W) - 1);

  state_e                 state_q;
  logic [PW-1:0]          prod_q, prod_d;
  logic signed [EIW-1:0]  exp_q, exp_d;
  logic                   sticky_q, sticky_d;
  logic                   sign_q;
  logic                   norm_done_d;
  logic [X-1:0]           out_q;
  logic                   out_valid_q, overflow_q, underflow_q, inexact_q;

  // One normalisation action per cycle, highest priority first.
  always_comb begin
    prod_d      = prod_q;
    exp_d       = exp_q;
    sticky_d    = sticky_q;
    norm_done_d = 1'b0;
    if (prod_q[PW-1]) begin
      prod_d      = prod_q >> 1;
      exp_d       = exp_q + C_EXP_ONE;
      sticky_d    = sticky_q | prod_q[0];
      norm_done_d = !exp_q[EIW-1];
    end else if (exp_q < C_EXP_ONE) begin
      if (exp_q < C_EXP_FLOOR) begin
        prod_d   = '0;
        sticky_d = sticky_q | (|prod_q);
        exp_d    = C_EXP_ONE;
      end else begin
        prod_d   = prod_q >> 1;
        sticky_d = sticky_q | prod_q[0];
        exp_d    = exp_q + C_EXP_ONE;
      end
    end else if (!prod_q[PW-2] && (exp_q > C_EXP_ONE) && (prod_q != '0)) begin
      prod_d = prod_q << 1;
      exp_d  = exp_q - C_EXP_ONE;
    end else begin
      norm_done_d = 1'b1;
    end
  end

  logic [M:0]             w_sig_r;
  logic signed [EIW-1:0]  w_exp_r;
  logic                   w_carry, w_inexact, w_hidden, w_ovf, w_unf;
  logic [EXP_W-1:0]       w_field;
  logic [X-1:0]           w_res;

  fp_round_rne #(.MAN_W(M), .EW(EIW)) u_rne (
    .sig_i     (prod_q[PW-2:M]),
    .g_i       (prod_q[M-1]),
    .s_i       ((|prod_q[M-2:0]) | sticky_q),
    .exp_i     (exp_q),
    .sig_o     (w_sig_r),
    .exp_o     (w_exp_r),
    .carry_o   (w_carry),
    .inexact_o (w_inexact)
  );

  // A subnormal rounding up to 1.0 sets the hidden bit; its exponent is already 1.
  always_comb begin
    w_hidden = w_carry | w_sig_r[M];
    w_field  = w_hidden ? w_exp_r[EXP_W-1:0] : '0;
    w_ovf    = (w_exp_r >= C_EXP_MAX);
    if (w_ovf) begin
      w_res = {sign_q, {EXP_W{1'b1}}, {M{1'b0}}};
    end else begin
      w_res = {sign_q, w_field, w_sig_r[M-1:0]};
    end
    w_unf = !w_ovf && (w_field == '0) && w_inexact;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prod_q      <= '0;
      exp_q       <= '0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_special) begin
              out_q       <= in_special_word;
              overflow_q  <= 1'b0;
              underflow_q <= 1'b0;
              inexact_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              sign_q   <= in_sign;
              exp_q    <= {in_exp[EXP_W+1], in_exp};
              prod_q   <= in_prod;
              sticky_q <= 1'b0;
              state_q  <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          prod_q   <= prod_d;
          exp_q    <= exp_d;
          sticky_q <= sticky_d;
          if (norm_done_d) state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          out_q       <= w_res;
          overflow_q  <= w_ovf;
          underflow_q <= w_unf;
          inexact_q   <= w_inexact | w_ovf;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

`default_nettype wire
